// File: rtl/uart_pkg.sv
// Shared definitions for the UART capture receiver.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  // Receiver FSM state encoding
  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_HIGH = 3'd4
  } rx_state_t;

  // Clock cycles per bit, rounded to nearest
  function automatic int bit_cycles(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; occupancy counter drives full/empty, pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  // a push into a full FIFO only lands if a pop frees the slot in the same cycle
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage, pointers and occupancy
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

endmodule

// File: rtl/uart_rx_capture.sv
// 8N1 UART receiver feeding a byte FIFO with a valid/ready output stream.
//
// state        | meaning
// RX_IDLE      | line idle, waiting for a falling edge on rxs
// RX_START     | timing to mid start bit, rejecting glitches
// RX_DATA      | sampling 8 data bits LSB first, one per bit time
// RX_STOP      | timing to mid stop bit, push byte or flag framing error
// RX_WAIT_HIGH | after a framing error, waiting for the line to go high
module uart_rx_capture
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 25000000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               rxd,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [UART_DATA_BITS-1:0]          out_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    level,
  output logic                               frame_err,
  output logic                               overflow,
  input  logic                               clear_overflow
);

  localparam int BIT_CYCLES  = bit_cycles(CLK_FREQ_HZ, BAUD);
  localparam int HALF_CYCLES = BIT_CYCLES / 2;
  localparam int CW          = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] BIT_TC  = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] HALF_TC = CW'(HALF_CYCLES - 1);
  localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic                      rxd_meta;
  logic                      rxs;
  logic                      rxs_prev;
  rx_state_t                 state;
  logic [CW-1:0]             cnt;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      stop_tick;
  logic                      push;
  logic                      pop;
  logic                      fifo_full;
  logic                      fifo_empty;

  assign stop_tick = (state == RX_STOP) && (cnt == BIT_TC);
  assign push      = stop_tick && rxs;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  // Two-flop synchronizer plus previous-sample register for edge detect
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rxd_meta <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxs      <= rxd_meta;
      rxs_prev <= rxs;
    end
  end

  // Frame decode FSM with bit-time counter and shift register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      unique case (state)
        RX_IDLE: begin
          if (!rxs && rxs_prev) begin
            cnt   <= '0;
            state <= RX_START;
          end
        end
        RX_START: begin
          if (cnt == HALF_TC) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rxs ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == BIT_TC) begin
            cnt            <= '0;
            shreg[bit_idx] <= rxs;
            bit_idx        <= bit_idx + 1'b1;
            if (bit_idx == LAST_BIT) state <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == BIT_TC) begin
            cnt   <= '0;
            state <= rxs ? RX_IDLE : RX_WAIT_HIGH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_WAIT_HIGH: begin
          if (rxs) state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  // Framing-error pulse and sticky overflow flag (set beats clear)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      frame_err <= stop_tick && !rxs;
      if (push && fifo_full && !pop) overflow <= 1'b1;
      else if (clear_overflow)       overflow <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .wdata (shreg),
    .pop   (pop),
    .rdata (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

endmodule

// File: tb/tb_uart_rx_capture.sv
// Bench for uart_rx_capture: serial frames in, byte stream checked against a queue model.
module tb_uart_rx_capture;

  localparam int BIT   = 217;
  localparam int DEPTH = 16;
  localparam int PER   = 40;
  // stop sample edge relative to the edge after which the start bit is driven:
  // 2 sync flops + 1 edge-detect cycle + half bit + 9 full bits
  localparam int STOP_EDGE = 3 + 108 + 9 * BIT;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rxd = 1'b1;
  logic       out_ready = 1'b0;
  logic       clear_overflow = 1'b0;
  logic       out_valid;
  logic [7:0] out_data;
  logic [4:0] level;
  logic       frame_err;
  logic       overflow;

  always #(PER / 2) clock = ~clock;

  uart_rx_capture dut (
    .clock          (clock),
    .reset          (reset),
    .rxd            (rxd),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .level          (level),
    .frame_err      (frame_err),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  int           n_checks = 0;
  int           n_bad = 0;
  byte unsigned model_q[$];
  logic         exp_ovf = 1'b0;
  int           exp_fe = 0;
  int           fe_pulses = 0;
  int           fe_cycles = 0;
  logic         fe_prev = 1'b0;
  logic         ov_prev = 1'b0;
  time          last_rise = 0;
  time          p0_time = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Output monitor: stream pops against the model, frame_err pulse accounting
  always @(negedge clock) begin
    if (!reset) begin
      if (frame_err) fe_cycles++;
      if (frame_err && !fe_prev) fe_pulses++;
      if (out_valid && !ov_prev) last_rise = $time;
      if (out_valid && out_ready) begin
        chk("pop_avail", 32'(model_q.size() != 0), 32'd1);
        if (model_q.size() != 0) chk("pop_data", 32'(out_data), 32'(model_q.pop_front()));
      end
    end
    fe_prev = frame_err;
    ov_prev = out_valid;
  end

  function automatic logic frame_bit(input logic [7:0] d, input logic stop_val, input int c);
    int b;
    b = c / BIT;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    return stop_val;
  endfunction

  // rdy_mode: 0 leave out_ready alone, 1 pulse it on cycle pop_at, 2 randomize
  task automatic send_frame(input logic [7:0] d, input logic stop_ok, input int stop_len,
                            input int gap, input int rdy_mode, input int pop_at);
    int total;
    total = BIT * (9 + stop_len);
    for (int c = 0; c < total; c++) begin
      @(posedge clock);
      if (c == 0) p0_time = $time;
      #1;
      rxd = frame_bit(d, stop_ok, c);
      if (c == 9 * BIT) begin
        if (!stop_ok) exp_fe++;
        else if (model_q.size() < DEPTH || rdy_mode == 1) model_q.push_back(d);
        else exp_ovf = 1'b1;
      end
      if (rdy_mode == 1) out_ready = (c == pop_at);
      else if (rdy_mode == 2) out_ready = 1'($urandom_range(0, 1));
    end
    for (int g = 0; g < gap; g++) begin
      @(posedge clock);
      #1;
      rxd = 1'b1;
      if (rdy_mode == 2) out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    #(64'd99000 * PER);
    $display("FAIL watchdog: simulation time limit reached, checks=%0d bad=%0d", n_checks, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (5) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_fe", 32'(frame_err), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);

    // single frame, held in the FIFO
    idle(10);
    send_frame(8'h55, 1'b1, 1, 20, 0, 0);
    chk("t1_rise_time", 32'(last_rise - p0_time), 32'(STOP_EDGE * PER + PER / 2));
    chk("t1_level", 32'(level), 32'(model_q.size()));
    chk("t1_data", 32'(out_data), 32'h55);
    chk("t1_fe", 32'(fe_pulses), 32'(exp_fe));
    out_ready = 1'b1;
    idle(5);
    chk("t1_drain", 32'(level), 32'd0);

    // back-to-back frames, consumer always ready
    send_frame(8'h00, 1'b1, 1, 0, 0, 0);
    send_frame(8'hFF, 1'b1, 1, 0, 0, 0);
    send_frame(8'hA5, 1'b1, 1, 20, 0, 0);
    chk("t2_level", 32'(level), 32'd0);
    chk("t2_model", 32'(model_q.size()), 32'd0);

    // short low glitch on the idle line
    rxd = 1'b0;
    idle(50);
    rxd = 1'b1;
    idle(300);
    chk("t3_level", 32'(level), 32'd0);
    chk("t3_fe", 32'(fe_pulses), 32'(exp_fe));
    send_frame(8'h3C, 1'b1, 1, 20, 0, 0);
    chk("t3_model", 32'(model_q.size()), 32'd0);

    // low stop bit held as a break, then recovery
    send_frame(8'h81, 1'b0, 30, BIT, 0, 0);
    chk("t4_fe_pulses", 32'(fe_pulses), 32'(exp_fe));
    chk("t4_fe_cycles", 32'(fe_cycles), 32'(exp_fe));
    chk("t4_level", 32'(level), 32'd0);
    send_frame(8'h42, 1'b1, 1, 20, 0, 0);
    chk("t4_model", 32'(model_q.size()), 32'd0);

    // fill past capacity with the consumer stalled
    out_ready = 1'b0;
    for (int i = 0; i <= DEPTH; i++) send_frame(8'(i), 1'b1, 1, 0, 0, 0);
    idle(5);
    chk("t5_level_full", 32'(level), 32'(model_q.size()));
    chk("t5_ovf_set", 32'(overflow), 32'(exp_ovf));
    clear_overflow = 1'b1;
    exp_ovf = 1'b0;
    idle(1);
    clear_overflow = 1'b0;
    idle(1);
    chk("t5_ovf_clr", 32'(overflow), 32'(exp_ovf));
    // push into a full FIFO with a pop in the very same cycle
    send_frame(8'h11, 1'b1, 1, 5, 1, STOP_EDGE - 1);
    chk("t5_ovf_simul", 32'(overflow), 32'(exp_ovf));
    chk("t5_level_simul", 32'(level), 32'(model_q.size()));
    out_ready = 1'b1;
    idle(40);
    chk("t5_drain", 32'(level), 32'd0);
    chk("t5_model", 32'(model_q.size()), 32'd0);

    // reset in the middle of a frame
    out_ready = 1'b0;
    send_frame(8'h77, 1'b1, 1, 10, 0, 0);
    chk("t6_pre_level", 32'(level), 32'd1);
    for (int c = 0; c < 4 * BIT + 50; c++) begin
      @(posedge clock);
      #1;
      rxd = frame_bit(8'h99, 1'b1, c);
    end
    @(negedge clock);
    #3;
    reset = 1'b1;
    model_q.delete();
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_level", 32'(level), 32'd0);
    chk("t6_rst_data", 32'(out_data), 32'd0);
    chk("t6_rst_ovf", 32'(overflow), 32'd0);
    rxd = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    out_ready = 1'b1;
    idle(20);
    send_frame(8'h5A, 1'b1, 1, 20, 0, 0);
    chk("t6_model", 32'(model_q.size()), 32'd0);
    chk("t6_level", 32'(level), 32'd0);

    // randomized frames, stop errors and consumer stalls
    for (int n = 0; n < 3; n++) begin
      logic [7:0] d;
      logic       ok;
      d  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 3) != 0);
      send_frame(d, ok, 1, ok ? $urandom_range(0, 40) : $urandom_range(2, 40), 2, 0);
    end
    out_ready = 1'b1;
    idle(40);
    chk("rnd_model", 32'(model_q.size()), 32'd0);
    chk("rnd_level", 32'(level), 32'd0);
    chk("end_fe_pulses", 32'(fe_pulses), 32'(exp_fe));
    chk("end_fe_cycles", 32'(fe_cycles), 32'(exp_fe));
    chk("end_ovf", 32'(overflow), 32'(exp_ovf));

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_capture.md
Name: uart_rx_capture

Overview:
- Synthesizable UART receiver sitting directly downstream of the SoC `uart_tx` pin; it replaces the behavioural tty console as the consumer of UART output.
- Decodes 8N1 serial frames and buffers received bytes in a FIFO.
- Presents the bytes on a valid/ready stream to a bench checker or an FPGA-side logger.
- Reports framing errors and FIFO overflow.

Parameters:
- CLK_FREQ_HZ, 25000000, frequency of `clock` in Hz.
- BAUD, 115200, line rate in bit/s.
- FIFO_DEPTH, 16, byte FIFO entries; must be a power of two, minimum 2.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- rxd  in  1  serial input, idle high, connected to SoC `uart_tx`.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts `out_data` when high with `out_valid`.
- out_data  out  8  FIFO head byte.
- level  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.
- frame_err  out  1  one-cycle pulse when a stop bit is sampled low.
- overflow  out  1  sticky; set when a good byte arrives while the FIFO is full.
- clear_overflow  in  1  synchronous clear of `overflow`.

Behaviour:
- Constants:
  - BIT_CYCLES = (CLK_FREQ_HZ + BAUD/2) / BAUD, which is 217 at the defaults.
  - HALF_CYCLES = BIT_CYCLES/2, which is 108.
  - Bit counter is wide enough for BIT_CYCLES-1.
- Synchronizer:
  - Two flops on `rxd`, both reset to 1.
  - `rxs` is the second flop output, giving 2-cycle input latency.
- Reset values: out_valid=0, out_data=0, level=0, frame_err=0, overflow=0, state=IDLE, FIFO empty.
- Reset asserted mid-frame aborts the frame with no push. After release the FSM waits in IDLE for a falling edge.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: on `rxs`==0 with previous `rxs`==1, load the counter with 0 and go to START.
  - START: when the counter reaches HALF_CYCLES-1, sample `rxs`.
    - If 0: valid start, clear counter, bit index=0, go to DATA.
    - If 1: glitch, return to IDLE with no error.
  - DATA: every BIT_CYCLES cycles, sample `rxs` into shift register bit[index], LSB first. After index 7 is sampled, go to STOP.
  - STOP: after BIT_CYCLES cycles, sample `rxs` (mid stop bit).
    - If 1: push the byte into the FIFO and go to IDLE. Frames may be back-to-back with zero idle.
    - If 0: pulse `frame_err` for exactly 1 cycle, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rxs`==1, then go to IDLE. A break condition (line held low) therefore yields a single `frame_err`.
- FIFO:
  - Push occurs in the STOP sample cycle T.
  - `out_valid`, `out_data` and `level` update at T+1, all registered.
  - Pop happens when `out_valid && out_ready`.
  - `out_data` shows the head entry and stays stable while `out_valid && !out_ready`.
  - Push when full and no pop in the same cycle: byte dropped, `overflow` set, FIFO contents unchanged.
  - Push and pop in the same cycle when full: both accepted, `level` unchanged, no overflow.
  - Push and pop in the same cycle when empty is impossible, because `out_valid`=0.
  - Pointers are log2(FIFO_DEPTH) bits wide and wrap naturally. Full/empty are derived from `level`.
- Overflow flag:
  - `clear_overflow` in the same cycle as a new overflow event: the set wins.
  - `overflow` affects only the flag; reception continues.

Decomposition:
- Package uart_pkg holds:
  - the FSM state enum (rx_state_t);
  - a function bit_cycles(clk_hz, baud) returning the rounded divisor;
  - constant UART_DATA_BITS=8.
- Sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/level) holds the buffer. The receiver FSM stays in the top module.

Test Plan:
1. Reset, then drive the 8N1 frame 0x55 at 217 cycles/bit -> exactly one push; `out_valid` rises 1 cycle after the stop sample; `out_data`=0x55; `level`=1; `frame_err` never asserts.
2. Send 0x00, 0xFF, 0xA5 back-to-back with zero idle, `out_ready`=1 -> stream 0x00, 0xFF, 0xA5 in order; `level` returns to 0.
3. Drive a 50-cycle low glitch on idle `rxd` -> FSM returns to IDLE; no push; no `frame_err`. Then send 0x3C -> 0x3C received intact.
4. Send 0x81 with the stop bit low, holding `rxd` low for 30 bit times -> exactly one `frame_err` pulse; no push. After `rxd` returns high, send 0x42 -> 0x42 received.
5. Hold `out_ready`=0 and send 17 bytes 0x00..0x10 -> `level`=16 and `overflow`=1; popping yields 0x00..0x0F (0x10 dropped). Pulse `clear_overflow` -> 0. Repeat with a pop timed on the 17th push cycle -> no overflow.
6. Assert `reset` mid-DATA of byte 0x99 -> outputs return to reset values immediately; no partial byte. Send 0x5A after release -> 0x5A received.
